// File: rtl/seq_datapath.sv
// seq_datapath: micro-programmed sequencer driving a register file and ALU.
// A loadable program memory is stepped through by a FETCH/EXEC FSM with a
// start/busy/done handshake; a combinational debug port exposes any register.
module seq_datapath #(
   parameter int WIDTH      = 16,
   parameter int NREGS      = 16,
   parameter int PROG_DEPTH = 32,
   localparam int RW        = $clog2(NREGS),
   localparam int PW        = $clog2(PROG_DEPTH),
   localparam int IW        = 12 + 2*RW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prog_we,
   input  logic [PW-1:0]    prog_addr,
   input  logic [IW-1:0]    prog_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [4:0]       flags,
   input  logic [RW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   // opcodes
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hA;
   localparam logic [3:0] OP_SHR  = 4'hB;
   localparam logic [3:0] OP_BNE  = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   // flag bit positions within {C, L, F, Z, N}
   localparam int FC = 4;
   localparam int FL = 3;
   localparam int FF = 2;
   localparam int FZ = 1;
   localparam int FN = 0;

   localparam int MSB = WIDTH - 1;
   localparam logic [PW-1:0] PC_LAST = PW'(PROG_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_e;

   state_e           state_q;
   logic [PW-1:0]    pc_q;
   logic [IW-1:0]    ir_q;
   logic             busy_q, done_q;
   logic [4:0]       flags_q;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [IW-1:0]    mem_q  [PROG_DEPTH];

   // instruction fields
   logic [3:0]        op;
   logic [RW-1:0]     dst, src;
   logic signed [7:0] imm;
   assign op  = ir_q[IW-1 -: 4];
   assign dst = ir_q[IW-5 -: RW];
   assign src = ir_q[IW-5-RW -: RW];
   assign imm = ir_q[7:0];

   logic [WIDTH-1:0] rd, rs, sx, opb;
   logic [WIDTH:0]   add_w;
   logic [WIDTH-1:0] res_d;
   logic             wr_d, take_d;
   logic [4:0]       flags_d;
   logic             exec_st;

   assign rd      = regs_q[dst];
   assign rs      = regs_q[src];
   assign sx      = WIDTH'(imm);
   assign opb     = (op == OP_ADDI) ? sx : rs;
   assign add_w   = {1'b0, rd} + {1'b0, opb};
   assign exec_st = (state_q == S_EXEC);

   // ALU, flag and branch decode for the instruction held in ir_q
   always_comb begin
      res_d   = rd;
      wr_d    = 1'b0;
      take_d  = 1'b0;
      flags_d = flags_q;
      case (op)
         OP_ADD, OP_ADDI: begin
            res_d       = add_w[MSB:0];
            wr_d        = 1'b1;
            flags_d[FC] = add_w[WIDTH];
            flags_d[FF] = (rd[MSB] == opb[MSB]) && (res_d[MSB] != rd[MSB]);
            flags_d[FZ] = (res_d == '0);
            flags_d[FN] = res_d[MSB];
         end
         OP_SUB: begin
            res_d       = rd - rs;
            wr_d        = 1'b1;
            flags_d[FC] = (rd < rs);
            flags_d[FF] = (rd[MSB] != rs[MSB]) && (res_d[MSB] != rd[MSB]);
            flags_d[FZ] = (res_d == '0);
            flags_d[FN] = res_d[MSB];
         end
         OP_AND: begin
            res_d       = rd & rs;
            wr_d        = 1'b1;
            flags_d[FZ] = (res_d == '0);
         end
         OP_OR: begin
            res_d       = rd | rs;
            wr_d        = 1'b1;
            flags_d[FZ] = (res_d == '0);
         end
         OP_XOR: begin
            res_d       = rd ^ rs;
            wr_d        = 1'b1;
            flags_d[FZ] = (res_d == '0);
         end
         OP_MOV: begin
            res_d = rs;
            wr_d  = 1'b1;
         end
         OP_LDI: begin
            res_d = sx;
            wr_d  = 1'b1;
         end
         OP_CMP: begin
            flags_d[FL] = (rd < rs);
            flags_d[FN] = ($signed(rd) < $signed(rs));
            flags_d[FZ] = (rd == rs);
         end
         OP_SHL: begin
            res_d       = {rd[MSB-1:0], 1'b0};
            wr_d        = 1'b1;
            flags_d[FC] = rd[MSB];
            flags_d[FZ] = (res_d == '0);
         end
         OP_SHR: begin
            res_d       = {1'b0, rd[MSB:1]};
            wr_d        = 1'b1;
            flags_d[FC] = rd[0];
            flags_d[FZ] = (res_d == '0);
         end
         OP_BNE:  take_d = ~flags_q[FZ];
         OP_JMP:  take_d = 1'b1;
         default: ;  // NOP, 0xE and HALT touch no datapath state
      endcase
   end

   // sequencer FSM: owns pc, instruction register and the handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_FETCH;
                  pc_q    <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_FETCH: begin
               ir_q    <= mem_q[pc_q];
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               if (take_d) begin
                  pc_q    <= imm[PW-1:0];
                  state_q <= S_FETCH;
               end else if (op == OP_HALT || pc_q == PC_LAST) begin
                  // pc never wraps: falling off the end terminates the run
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  pc_q    <= pc_q + 1'b1;
                  state_q <= S_FETCH;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // register file write-back; reads inside EXEC see the pre-write value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (exec_st && wr_d) begin
         regs_q[dst] <= res_d;
      end
   end

   // flag register, updated once per executed instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        flags_q <= '0;
      else if (exec_st) flags_q <= flags_d;
   end

   // program memory is deliberately outside reset so programs survive it
   always_ff @(posedge clk) begin
      if (prog_we && !busy_q) mem_q[prog_addr] <= prog_data;
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign flags    = flags_q;
   assign dbg_data = regs_q[dbg_sel];

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised sequencer-plus-datapath: a loadable micro-program memory drives a register file and ALU through a fetch/execute FSM with a start/busy/done handshake. This is the next generation of the fixed FSM/datapath pairing, generalised in data width, register count and program depth, and it adds branching, halt and a debug read port. It sits under the board top, which loads programs and drives the 7-seg display from the debug port.

## Interface
- WIDTH, 16: datapath and register width (≥8).
- NREGS, 16: register count (power of 2); RW = log2(NREGS).
- PROG_DEPTH, 32: program words (power of 2, ≤256); PW = log2(PROG_DEPTH); IW = 12+2·RW.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears everything except program memory.
- prog_we  in  1  program write strobe; ignored while busy.
- prog_addr  in  PW  program write address.
- prog_data  in  IW  instruction word {op[3:0], dst[RW-1:0], src[RW-1:0], imm[7:0]}.
- start  in  1  run request; accepted only in IDLE.
- busy  out  1  high in FETCH and EXEC.
- done  out  1  one-cycle pulse in DONE.
- flags  out  5  {C, L, F, Z, N}.
- dbg_sel  in  RW  register select for debug read.
- dbg_data  out  WIDTH  combinational read of regs[dbg_sel].

## Operation
- States: IDLE → (start) FETCH → EXEC → FETCH | DONE → IDLE.
- FETCH: synchronous program read at pc.
- EXEC: execute, write back, update flags and pc. Go to DONE on HALT or when pc = PROG_DEPTH-1 and no branch is taken; otherwise go to FETCH. pc never wraps.
- Entering FETCH from IDLE clears pc to 0; registers and flags persist between runs.
- sx(imm) means imm sign-extended to WIDTH. All arithmetic is mod 2^WIDTH.
- Opcodes:
  - 0 NOP
  - 1 ADD: d = d+s
  - 2 SUB: d = d−s
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV: d = s
  - 7 LDI: d = sx(imm)
  - 8 ADDI: d = d+sx(imm)
  - 9 CMP: flags only
  - A SHL: d = d<<1
  - B SHR: d = d>>1 (logical)
  - C BNE: if Z=0 then pc = imm[PW-1:0]
  - D JMP: pc = imm[PW-1:0]
  - F HALT
  - E: treated as NOP.
- Flag updates:
  - ADD/ADDI: C = carry-out, F = signed overflow, Z = (result==0), N = result MSB.
  - SUB: C = borrow (d<s unsigned), F = signed overflow, Z, N.
  - CMP: L = d<s unsigned, N = d<s signed, Z = (d==s).
  - AND/OR/XOR/SHL/SHR: Z only; for shifts, C = the bit shifted out.
  - All other ops leave flags unchanged. A flag not listed for an op holds its value.
- dst = src is legal; reads use the pre-write value.
- Program writes in IDLE/DONE take effect on the next clock edge.

## Timing
- Reset values: state IDLE, pc 0, all registers 0, flags 0, busy 0, done 0. Program memory is not cleared.
- Reset mid-run: busy and done drop asynchronously; the next start runs from address 0 with zeroed registers.
- start sampled high in IDLE at edge k: busy=1 from k+1. Each instruction takes 2 cycles (FETCH, EXEC).
- A run executing M instructions, including the final one: busy for 2M cycles; done=1 in the following cycle, with busy=0; back in IDLE the cycle after that.
- Register and flag results of an EXEC are visible on dbg_data/flags from the next cycle.
- start in FETCH/EXEC/DONE is ignored; it is not queued.

## Test plan
- Reset: assert reset mid-cycle → busy=0, done=0, flags=0, dbg_data=0 for every dbg_sel immediately.
- Program [LDI r1,5; LDI r2,3; ADD r1,r2; HALT], start → busy 8 cycles, done pulse at cycle 9, r1=8, r2=3, flags C=0, Z=0, N=0.
- Program [LDI r1,−1; LDI r2,1; ADD r1,r2; HALT] → r1=0x0000, C=1, Z=1, F=0. Then [LDI r1,0x7F; SHL×9; HALT] → r1=0xFE00, N unchanged by SHL, C=0.
- Loop [LDI r1,3; LDI r2,1; SUB r1,r2; BNE 2; HALT] → 9 instructions, busy 18 cycles, r1=0, Z=1.
- No HALT, PROG_DEPTH=32 filled with NOP → done after 64 busy cycles. Mid-run start and prog_we are ignored: program readback is unchanged and the run length is unaffected.
- Reset asserted during the loop test's 5th cycle → immediate idle, registers 0. Re-start completes normally with r1=0.
